banked_mem_arbiter: RTL



---
 rtl/banked_mem_arbiter_pkg.sv | 21 ++
 rtl/banked_mem_arbiter_rr_arbiter.sv | 32 +++
 rtl/banked_mem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/banked_mem_arbiter_pkg.sv
// Shared width helpers for the banked SRAM controller and its arbiters.
package mem_ctrl_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  function automatic int bank_idx_w(input int nbanks);
    return clog2(nbanks);
  endfunction

  function automatic int offset_w(input int depth);
    return clog2(depth);
  endfunction

endpackage

// File: rtl/banked_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr, plus the pointer
// to use next cycle (one past the winner, or unchanged when idle).
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  always_comb begin
    int   idx;
    logic found;
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        next_ptr = PW'((idx + 1) % N);
      end
    end
  end

endmodule

// File: rtl/banked_mem_arbiter.sv
// Multi-port, multi-bank SRAM controller: per-bank round-robin arbitration with
// valid/ready requests and a one-cycle read response per port.
module banked_mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int NPORTS     = 4,
  parameter int NBANKS     = 4,
  parameter int BANK_DEPTH = 1024,
  parameter int DATA_W     = 32,
  localparam int ADDR_W    = bank_idx_w(NBANKS) + offset_w(BANK_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NPORTS-1:0]        req_valid,
  input  logic [NPORTS-1:0]        req_we,
  input  logic [NPORTS*ADDR_W-1:0] req_addr,
  input  logic [NPORTS*DATA_W-1:0] req_wdata,
  output logic [NPORTS-1:0]        req_ready,
  output logic [NPORTS-1:0]        rsp_valid,
  output logic [NPORTS*DATA_W-1:0] rsp_rdata
);

  localparam int BW = bank_idx_w(NBANKS);
  localparam int OW = offset_w(BANK_DEPTH);
  localparam int PW = clog2(NPORTS);

  logic [NPORTS-1:0][BW-1:0]     port_bank;
  logic [NPORTS-1:0][OW-1:0]     port_off;
  logic [NBANKS-1:0][NPORTS-1:0] bank_req;
  logic [NBANKS-1:0][NPORTS-1:0] bank_gnt;
  logic [NBANKS-1:0][DATA_W-1:0] bank_rdata;
  logic [NPORTS-1:0][BW-1:0]     rsp_bank_q;
  logic [NPORTS-1:0][DATA_W-1:0] rdata_hold;

  always_comb begin
    port_bank = '0;
    port_off  = '0;
    bank_req  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      port_bank[p] = req_addr[p*ADDR_W + OW +: BW];
      port_off[p]  = req_addr[p*ADDR_W +: OW];
    end
    for (int b = 0; b < NBANKS; b++) begin
      for (int p = 0; p < NPORTS; p++) begin
        bank_req[b][p] = req_valid[p] && (port_bank[p] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_next;
    logic              sel_we;
    logic [OW-1:0]     sel_off;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [BANK_DEPTH];

    rr_arbiter #(.N(NPORTS)) u_arb (
      .req      (bank_req[b]),
      .ptr      (ptr_q),
      .gnt      (bank_gnt[b]),
      .next_ptr (ptr_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr_q <= '0;
      else          ptr_q <= ptr_next;
    end

    // Grant is one-hot, so at most one port's fields reach this bank.
    always_comb begin
      sel_we    = 1'b0;
      sel_off   = '0;
      sel_wdata = '0;
      for (int p = 0; p < NPORTS; p++) begin
        if (bank_gnt[b][p]) begin
          sel_we    = req_we[p];
          sel_off   = port_off[p];
          sel_wdata = req_wdata[p*DATA_W +: DATA_W];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (|bank_gnt[b]) begin
        if (sel_we) mem[sel_off] <= sel_wdata;
        else        rd_q         <= mem[sel_off];
      end
    end

    assign bank_rdata[b] = rd_q;
  end

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NBANKS; b++) begin
      req_ready = req_ready | bank_gnt[b];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= '0;
      rsp_bank_q <= '0;
      rdata_hold <= '0;
    end else begin
      rsp_valid  <= req_ready & ~req_we;
      rsp_bank_q <= port_bank;
      rdata_hold <= rsp_rdata;
    end
  end

  // Bank read registers are shared, so idle ports replay their captured value.
  always_comb begin
    rsp_rdata = rdata_hold;
    for (int p = 0; p < NPORTS; p++) begin
      if (rsp_valid[p]) rsp_rdata[p*DATA_W +: DATA_W] = bank_rdata[rsp_bank_q[p]];
    end
  end

endmodule
